// File: rtl/router_pkg.sv
// Shared router constants, FSM state encoding and round-robin index helper.
package router_pkg;

    localparam int NUM_PORTS = 8;
    localparam int ADDR_W    = 4;
    localparam int PAYLOAD_W = 32;
    localparam int IDX_W     = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Next index after idx, wrapping back to 0 after the last port.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/portout_arb_rr_arb8.sv
// Combinational 8-way round-robin picker: first requester after last_grant wins.
module rr_arb8
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic [NUM_PORTS-1:0] winner_o,
    output logic [IDX_W-1:0]     winner_idx_o,
    output logic                 any_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        winner_o     = '0;
        winner_idx_o = last_grant_i;
        any_o        = |req_i;
        cand         = last_grant_i;
        found        = 1'b0;
        // Walk the ring once starting just after the previous winner.
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = rr_next(cand);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                winner_o[cand] = 1'b1;
                winner_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/portout_arb.sv
// Output-port arbiter: buffers one matching packet per input, picks round-robin, sends LSB first.
// Optional saturating sent-packet counter enabled by PORTOUT_ARB_PKT_COUNT_EN.
module portout_arb #(
    parameter int NUM_IN    = 8,
    parameter int ADDR_W    = 4,
    parameter int PAYLOAD_W = 32,
    parameter int PORT_ID   = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_IN-1:0]             req_vld,
    input  logic [NUM_IN*ADDR_W-1:0]      req_addr,
    input  logic [NUM_IN*PAYLOAD_W-1:0]   req_payload,
    output logic [NUM_IN-1:0]             grant,
    output logic [NUM_IN-1:0]             drop,
    output logic                          frameo_n,
    output logic                          valido_n,
    output logic                          dout,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);
    import router_pkg::state_e;
    import router_pkg::IDLE;
    import router_pkg::SEND;
    import router_pkg::GAP;
    import router_pkg::IDX_W;

    localparam int CNT_W = $clog2(PAYLOAD_W + 1);

    state_e                 state_q;
    logic [IDX_W-1:0]       last_grant_q;
    logic [PAYLOAD_W-1:0]   shift_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic                   frameo_n_q;
    logic                   valido_n_q;
    logic                   dout_q;
    logic                   busy_q;
    logic [NUM_IN-1:0]      grant_q;
    logic [NUM_IN-1:0]      drop_q;
    logic [NUM_IN-1:0]      drop_d;
    logic [NUM_IN-1:0]      pending_q;
    logic [NUM_IN-1:0]      pending_d;
    logic [PAYLOAD_W-1:0]   slot_q [NUM_IN];

    logic [NUM_IN-1:0]      match;
    logic [NUM_IN-1:0]      store;
    logic [NUM_IN-1:0]      grant_now;
    logic [NUM_IN-1:0]      winner;
    logic [IDX_W-1:0]       winner_idx;
    logic                   any_req;

    rr_arb8 u_rr (
        .req_i        (pending_q),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .winner_idx_o (winner_idx),
        .any_o        (any_req)
    );

    assign grant_now = (state_q == IDLE && any_req) ? winner : '0;

    // A slot being granted this edge frees up in time to take a new packet.
    always_comb begin
        match     = '0;
        store     = '0;
        drop_d    = '0;
        pending_d = pending_q & ~grant_now;
        for (int i = 0; i < NUM_IN; i++) begin
            match[i] = req_vld[i] && (req_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(PORT_ID));
            if (match[i]) begin
                if (!pending_q[i] || grant_now[i]) begin
                    store[i]     = 1'b1;
                    pending_d[i] = 1'b1;
                end else begin
                    drop_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (store[i]) begin
                slot_q[i] <= req_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // bit_cnt_q counts bits already on the line; bit 0 leaves with the grant.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_IN - 1);
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            frameo_n_q   <= 1'b1;
            valido_n_q   <= 1'b1;
            dout_q       <= 1'b0;
            busy_q       <= 1'b0;
            grant_q      <= '0;
        end else begin
            grant_q <= grant_now;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        shift_q      <= slot_q[winner_idx] >> 1;
                        dout_q       <= slot_q[winner_idx][0];
                        valido_n_q   <= 1'b0;
                        frameo_n_q   <= (PAYLOAD_W == 1);
                        bit_cnt_q    <= CNT_W'(1);
                        last_grant_q <= winner_idx;
                        busy_q       <= 1'b1;
                        state_q      <= SEND;
                    end else begin
                        frameo_n_q <= 1'b1;
                        valido_n_q <= 1'b1;
                        dout_q     <= 1'b0;
                    end
                end
                SEND: begin
                    if (bit_cnt_q == CNT_W'(PAYLOAD_W)) begin
                        frameo_n_q <= 1'b1;
                        valido_n_q <= 1'b1;
                        dout_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= GAP;
                    end else begin
                        dout_q     <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        valido_n_q <= 1'b0;
                        frameo_n_q <= (bit_cnt_q == CNT_W'(PAYLOAD_W - 1));
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    frameo_n_q <= 1'b1;
                    valido_n_q <= 1'b1;
                    dout_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign drop     = drop_q;
    assign frameo_n = frameo_n_q;
    assign valido_n = valido_n_q;
    assign dout     = dout_q;
    assign busy     = busy_q;

`ifdef PORTOUT_ARB_PKT_COUNT_EN
    logic        send_done;
    logic [15:0] pkt_count_q;
    logic [15:0] pkt_count_d;

    assign send_done = (state_q == SEND) && (bit_cnt_q == CNT_W'(PAYLOAD_W));

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (send_done && pkt_count_q != 16'hFFFF) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_portout_arb.sv
// Self-checking bench for portout_arb: frame and grant scoreboards plus per-scenario tasks.
module tb_portout_arb;

  localparam int NI  = 8;
  localparam int AW  = 4;
  localparam int PW  = 32;
  localparam int PID = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NI-1:0]     req_vld = '0;
  logic [NI*AW-1:0]  req_addr = '0;
  logic [NI*PW-1:0]  req_payload = '0;
  logic [NI-1:0]     grant;
  logic [NI-1:0]     drop;
  logic              frameo_n;
  logic              valido_n;
  logic              dout;
  logic              busy;
  logic [15:0]       pkt_count;

  portout_arb #(
    .NUM_IN    (NI),
    .ADDR_W    (AW),
    .PAYLOAD_W (PW),
    .PORT_ID   (PID)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_vld     (req_vld),
    .req_addr    (req_addr),
    .req_payload (req_payload),
    .grant       (grant),
    .drop        (drop),
    .frameo_n    (frameo_n),
    .valido_n    (valido_n),
    .dout        (dout),
    .busy        (busy),
    .pkt_count   (pkt_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  logic [NI-1:0] gnt_q[$];
  int            gnt_cyc_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            exp_pkts = 0;
  bit            mon_en = 1'b0;
  int            bit_idx = 0;
  logic [PW-1:0] rx_word;
  logic [PW-1:0] exp_w;
  logic [NI-1:0] exp_g;
  logic          exp_f;

  always @(negedge clock) begin
    if (mon_en) begin
      if (grant !== '0) begin
        n_checks++;
        gnt_cyc_q.push_back(cyc);
        if (gnt_q.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected: got %b, required none", grant);
        end else begin
          exp_g = gnt_q.pop_front();
          if (grant !== exp_g) begin
            n_fail++;
            $display("FAIL grant_order: got %b, required %b", grant, exp_g);
          end
        end
      end
      n_checks++;
      if (busy !== ~valido_n) begin
        n_fail++;
        $display("FAIL busy: got %b, required %b", busy, ~valido_n);
      end
      if (valido_n === 1'b0) begin
        exp_f = (bit_idx == PW - 1);
        n_checks++;
        if (frameo_n !== exp_f) begin
          n_fail++;
          $display("FAIL frameo_n bit %0d: got %b, required %b", bit_idx, frameo_n, exp_f);
        end
        rx_word[bit_idx] = dout;
        bit_idx++;
        if (bit_idx == PW) begin
          bit_idx = 0;
          exp_pkts++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_unexpected: got %h, required none", rx_word);
          end else begin
            exp_w = exp_q.pop_front();
            if (rx_word !== exp_w) begin
              n_fail++;
              $display("FAIL frame_payload: got %h, required %h", rx_word, exp_w);
            end
          end
        end
      end else begin
        n_checks++;
        if (frameo_n !== 1'b1 || dout !== 1'b0 || bit_idx != 0) begin
          n_fail++;
          $display("FAIL idle_line: got frameo_n=%b dout=%b after %0d bits, required 1/0 after 0 bits",
                   frameo_n, dout, bit_idx);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [PW-1:0] p);
    req_vld[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_payload[i*PW +: PW] = p;
  endtask

  task automatic fire();
    @(posedge clock);
    #1;
    req_vld = '0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    gnt_q.delete();
    gnt_cyc_q.delete();
    bit_idx = 0;
    exp_pkts = 0;
    mon_en = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || gnt_q.size() != 0 || valido_n !== 1'b1) && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: timeout after %0d cycles, %0d frames still expected", n, exp_q.size());
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (frameo_n !== 1'b1 || valido_n !== 1'b1 || dout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_line: got %b%b%b, required 110", frameo_n, valido_n, dout);
    end
    n_checks++;
    if (grant !== '0 || drop !== '0) begin
      n_fail++;
      $display("FAIL reset_grant_drop: got %b/%b, required 0/0", grant, drop);
    end
    n_checks++;
    if (busy !== 1'b0 || pkt_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_busy_count: got %b/%0d, required 0/0", busy, pkt_count);
    end
    reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int lo = 0;
    logic [15:0] exp_cnt;
    set_req(3, AW'(PID), 32'hA5A5_0F0F);
    exp_q.push_back(32'hA5A5_0F0F);
    gnt_q.push_back(8'b0000_1000);
    fire();
    n_checks++;
    if (drop !== '0) begin
      n_fail++;
      $display("FAIL single_drop: got %b, required 0", drop);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (grant !== 8'b0000_1000 || valido_n !== 1'b0 || frameo_n !== 1'b0 || dout !== 1'b1) begin
      n_fail++;
      $display("FAIL single_start: got grant=%b valido_n=%b frameo_n=%b dout=%b, required 00001000/0/0/1",
               grant, valido_n, frameo_n, dout);
    end
    while (valido_n === 1'b0 && lo < 40) begin
      lo++;
      @(posedge clock);
      #1;
    end
    n_checks++;
    if (lo != PW) begin
      n_fail++;
      $display("FAIL single_len: got %0d valid cycles, required %0d", lo, PW);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (valido_n !== 1'b1 || frameo_n !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gap: got valido_n=%b frameo_n=%b busy=%b, required 1/1/0", valido_n, frameo_n, busy);
    end
    wait_idle(100);
`ifdef PORTOUT_ARB_PKT_COUNT_EN
    exp_cnt = 16'(exp_pkts);
`else
    exp_cnt = 16'd0;
`endif
    n_checks++;
    if (pkt_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL single_pkt_count: got %0d, required %0d", pkt_count, exp_cnt);
    end
  endtask

  task automatic test_addr_filter();
    set_req(2, AW'(PID + 1), $urandom);
    fire();
    n_checks++;
    if (drop !== '0) begin
      n_fail++;
      $display("FAIL filter_drop: got %b, required 0", drop);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if (grant !== '0 || valido_n !== 1'b1) begin
        n_fail++;
        $display("FAIL filter_idle: got grant=%b valido_n=%b, required 0/1", grant, valido_n);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NI; i++) begin
      set_req(i, AW'(PID), PW'(i));
      exp_q.push_back(PW'(i));
      gnt_q.push_back(NI'(1) << i);
    end
    gnt_cyc_q.delete();
    fire();
    wait_idle(NI * 40);
    n_checks++;
    if (gnt_cyc_q.size() != NI) begin
      n_fail++;
      $display("FAIL rr_grant_count: got %0d, required %0d", gnt_cyc_q.size(), NI);
    end else begin
      for (int i = 1; i < NI; i++) begin
        n_checks++;
        if (gnt_cyc_q[i] - gnt_cyc_q[i-1] != PW + 2) begin
          n_fail++;
          $display("FAIL rr_spacing %0d: got %0d cycles, required %0d", i, gnt_cyc_q[i] - gnt_cyc_q[i-1], PW + 2);
        end
      end
    end
  endtask

  task automatic test_fairness_wrap();
    logic [PW-1:0] p5, p2, p6;
    p5 = $urandom;
    p2 = $urandom;
    p6 = $urandom;
    set_req(5, AW'(PID), p5);
    exp_q.push_back(p5);
    gnt_q.push_back(8'b0010_0000);
    fire();
    repeat ($urandom_range(2, 6)) @(posedge clock);
    #1;
    set_req(2, AW'(PID), p2);
    set_req(6, AW'(PID), p6);
    exp_q.push_back(p6);
    gnt_q.push_back(8'b0100_0000);
    exp_q.push_back(p2);
    gnt_q.push_back(8'b0000_0100);
    fire();
    wait_idle(150);
  endtask

  task automatic test_overflow();
    logic [PW-1:0] pa, pb, pc;
    do_reset();
    pa = $urandom;
    pb = $urandom;
    pc = $urandom;
    set_req(0, AW'(PID), pa);
    set_req(1, AW'(PID), pb);
    exp_q.push_back(pa);
    gnt_q.push_back(8'b0000_0001);
    exp_q.push_back(pb);
    gnt_q.push_back(8'b0000_0010);
    fire();
    repeat (4) @(posedge clock);
    #1;
    set_req(1, AW'(PID), pc);
    fire();
    n_checks++;
    if (drop !== 8'b0000_0010) begin
      n_fail++;
      $display("FAIL overflow_drop: got %b, required 00000010", drop);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (drop !== '0) begin
      n_fail++;
      $display("FAIL overflow_drop_width: got %b, required 0", drop);
    end
    wait_idle(150);
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] p1, p2;
    do_reset();
    p1 = $urandom;
    p2 = $urandom;
    set_req(3, AW'(PID), p1);
    exp_q.push_back(p1);
    gnt_q.push_back(8'b0000_1000);
    fire();
    set_req(3, AW'(PID), p2);
    exp_q.push_back(p2);
    gnt_q.push_back(8'b0000_1000);
    fire();
    n_checks++;
    if (drop !== '0) begin
      n_fail++;
      $display("FAIL b2b_drop: got %b, required 0", drop);
    end
    wait_idle(150);
  endtask

  task automatic test_reset_mid_send();
    logic [PW-1:0] p0, p7;
    set_req(4, AW'(PID), $urandom);
    exp_q.push_back('0);
    gnt_q.push_back(8'b0001_0000);
    fire();
    set_req(6, AW'(PID), $urandom);
    fire();
    repeat (10) @(posedge clock);
    #1;
    n_checks++;
    if (valido_n !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midsend_active: got valido_n=%b busy=%b, required 0/1", valido_n, busy);
    end
    mon_en = 1'b0;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (frameo_n !== 1'b1 || valido_n !== 1'b1 || busy !== 1'b0 || dout !== 1'b0) begin
      n_fail++;
      $display("FAIL midsend_reset: got frameo_n=%b valido_n=%b busy=%b dout=%b, required 1/1/0/0",
               frameo_n, valido_n, busy, dout);
    end
    n_checks++;
    if (pkt_count !== 16'd0 || grant !== '0) begin
      n_fail++;
      $display("FAIL midsend_reset_cnt: got pkt_count=%0d grant=%b, required 0/0", pkt_count, grant);
    end
    reset_n = 1'b1;
    exp_q.delete();
    gnt_q.delete();
    bit_idx = 0;
    exp_pkts = 0;
    mon_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if (grant !== '0 || valido_n !== 1'b1) begin
        n_fail++;
        $display("FAIL midsend_pending_lost: got grant=%b valido_n=%b, required 0/1", grant, valido_n);
      end
    end
    p0 = $urandom;
    p7 = $urandom;
    set_req(7, AW'(PID), p7);
    set_req(0, AW'(PID), p0);
    exp_q.push_back(p0);
    gnt_q.push_back(8'b0000_0001);
    exp_q.push_back(p7);
    gnt_q.push_back(8'b1000_0000);
    fire();
    wait_idle(150);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_addr_filter();
    test_round_robin();
    test_fairness_wrap();
    test_overflow();
    test_back_to_back();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
